// File: rtl/mem_pkg.sv
// Purpose: shared types for the data memory, its byte banks, the core and the cache.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_pkg;

    localparam int LANES = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mem_state_t;

    // Lane i holds byte (aligned address + i); lane 0 is the LSB of the word.
    typedef logic [LANES-1:0][7:0] byte_lanes_t;

endpackage

// File: rtl/mem_byte_bank.sv
// Purpose: one 8-bit lane of the data array, synchronous write and synchronous read.
// Latency: read data appears one edge after rd_en; write commits on the wr_en edge.
// Backpressure: none; the owner strobes wr_en/rd_en exactly when an access completes.
module mem_byte_bank #(
    parameter int DEPTH_BITS = 14
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DEPTH_BITS-1:0] addr,
    input  logic [7:0]            wr_data,
    output logic [7:0]            rd_data
);

    logic [7:0] mem [0:(1<<DEPTH_BITS)-1];

    // Array write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    // Read register; only updated by a read, so it holds the last read byte.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            rd_data <= 8'h00;
        end else if (rd_en) begin
            rd_data <= mem[addr];
        end
    end

endmodule

// File: rtl/data_memory.sv
// Purpose: word-wide data memory behind the cache, request/ready handshake, byte lanes.
// Latency: mem_ready high in the cycle after edge N+LATENCY for a request accepted at edge N.
// Backpressure: mem_req is only sampled in IDLE; requests while mem_busy is high are dropped.
module data_memory
    import mem_pkg::*;
#(
    parameter int ADDR_BITS = 16,
    parameter int LATENCY   = 4
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        mem_req,
    input  logic [31:0] mem_addr,
    input  logic        mem_write_en,
    input  byte_lanes_t mem_data_in,
    output byte_lanes_t mem_data_out,
    output logic        mem_ready,
    output logic        mem_busy,
    output logic        mem_err
);

    localparam int IW = ADDR_BITS - 2;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    mem_state_t    state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx_q;
    logic          we_q;
    byte_lanes_t   din_q;
    logic          oor_q;
    logic          rd_zero;
    byte_lanes_t   bank_q;
    logic          fire;

    // Word alignment discards the two low address bits.
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_addr[1:0];

    // The access happens on the edge that leaves BUSY.
    assign fire = (state == BUSY) && (cnt == '0);

    // Sequencer: capture on acceptance, count down, complete, return to IDLE.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state     <= IDLE;
            cnt       <= '0;
            idx_q     <= '0;
            we_q      <= 1'b0;
            din_q     <= '0;
            oor_q     <= 1'b0;
            rd_zero   <= 1'b0;
            mem_ready <= 1'b0;
            mem_busy  <= 1'b0;
            mem_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        state    <= BUSY;
                        mem_busy <= 1'b1;
                        idx_q    <= mem_addr[ADDR_BITS-1:2];
                        we_q     <= mem_write_en;
                        din_q    <= mem_data_in;
                        oor_q    <= |mem_addr[31:ADDR_BITS];
                        cnt      <= CW'(LATENCY - 1);
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        state     <= DONE;
                        mem_ready <= 1'b1;
                        mem_err   <= oor_q;
                        // Writes leave the read lanes alone; out-of-range reads return zeros.
                        if (!we_q) begin
                            rd_zero <= oor_q;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    mem_ready <= 1'b0;
                    mem_busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // One bank per byte lane, all sharing the captured word index.
    for (genvar i = 0; i < LANES; i++) begin : g_bank
        mem_byte_bank #(
            .DEPTH_BITS (IW)
        ) u_bank (
            .clk     (clk),
            .rst_b   (rst_b),
            .wr_en   (fire && we_q && !oor_q),
            .rd_en   (fire && !we_q && !oor_q),
            .addr    (idx_q),
            .wr_data (din_q[i]),
            .rd_data (bank_q[i])
        );
    end

    assign mem_data_out = rd_zero ? '0 : bank_q;

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;
    import mem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Index 0: LATENCY=4 instance, index 1: LATENCY=1 instance.
    logic        rst  [2];
    logic        req  [2];
    logic [31:0] addr [2];
    logic        we   [2];
    byte_lanes_t din  [2];
    byte_lanes_t dout [2];
    logic        rdy  [2];
    logic        busy [2];
    logic        err  [2];

    data_memory #(.ADDR_BITS(16), .LATENCY(4)) dut4 (
        .clk(clk), .rst_b(rst[0]), .mem_req(req[0]), .mem_addr(addr[0]),
        .mem_write_en(we[0]), .mem_data_in(din[0]), .mem_data_out(dout[0]),
        .mem_ready(rdy[0]), .mem_busy(busy[0]), .mem_err(err[0]));

    data_memory #(.ADDR_BITS(16), .LATENCY(1)) dut1 (
        .clk(clk), .rst_b(rst[1]), .mem_req(req[1]), .mem_addr(addr[1]),
        .mem_write_en(we[1]), .mem_data_in(din[1]), .mem_data_out(dout[1]),
        .mem_ready(rdy[1]), .mem_busy(busy[1]), .mem_err(err[1]));

    typedef struct {
        logic [31:0] data;
        bit          chk_data;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        expq  [2][$];
    logic [7:0]  mdl   [2][65536];
    bit          known [2][65536];
    logic [31:0] last_rd [2];
    bit          last_k  [2];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(int d);
        return (d == 0) ? 4 : 1;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic fail(string nm);
        n_chk++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    function automatic logic [31:0] raddr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 63));
        if ($urandom_range(0, 5) == 0) a[31:16] = 16'($urandom_range(1, 65535));
        return a;
    endfunction

    // Reference model: a byte array plus "last value read" per instance.
    // Called at the negedge before the acceptance edge.
    task automatic accept(int d, logic w, logic [31:0] a, logic [31:0] dat);
        exp_t e;
        bit   oor;
        int   base;
        oor  = (a[31:16] != 16'h0);
        base = int'(a[15:0]) & 32'hFFFC;
        e.acc = cyc + 1;
        e.err = oor;
        e.data = '0;
        e.chk_data = 1'b1;
        if (w) begin
            if (!oor) begin
                for (int i = 0; i < 4; i++) begin
                    mdl[d][base+i]   = dat[8*i +: 8];
                    known[d][base+i] = 1'b1;
                end
            end
            e.data     = last_rd[d];
            e.chk_data = last_k[d];
        end else begin
            if (!oor) begin
                for (int i = 0; i < 4; i++) begin
                    e.data[8*i +: 8] = mdl[d][base+i];
                    if (!known[d][base+i]) e.chk_data = 1'b0;
                end
            end
            last_rd[d] = e.data;
            last_k[d]  = e.chk_data;
        end
        expq[d].push_back(e);
    endtask

    // Monitors: pop and compare whenever an instance signals completion.
    for (genvar g = 0; g < 2; g++) begin : g_mon
        logic prv = 1'b0;
        always @(negedge clk) begin
            exp_t e;
            if (rdy[g] === 1'b1) begin
                check("ready_one_cycle", 32'(prv), 32'd0);
                if (expq[g].size() == 0) begin
                    fail("unexpected_ready");
                end else begin
                    e = expq[g].pop_front();
                    check("ready_latency", cyc - e.acc, lat(g));
                    check("err", 32'(err[g]), 32'(e.err));
                    check("busy_with_ready", 32'(busy[g]), 32'd1);
                    if (e.chk_data) check("data_out", dout[g], e.data);
                end
            end
            prv = rdy[g];
        end
    end

    // One request: wait for IDLE, present for one edge, then scramble inputs until done.
    task automatic op(int d, logic w, logic [31:0] a, logic [31:0] dat);
        int t;
        t = 0;
        while (busy[d] !== 1'b0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) fail("idle_wait_timeout");
        req[d] = 1'b1; we[d] = w; addr[d] = a; din[d] = dat;
        accept(d, w, a, dat);
        @(negedge clk);
        req[d] = 1'b0;
        t = 0;
        while (expq[d].size() != 0 && t < 50) begin
            addr[d] = $urandom; din[d] = $urandom; we[d] = 1'($urandom);
            @(negedge clk);
            t++;
        end
        if (expq[d].size() != 0) fail("ready_timeout");
    endtask

    task automatic check_reset_outputs(int d);
        check("rst_ready", 32'(rdy[d]), 32'd0);
        check("rst_busy",  32'(busy[d]), 32'd0);
        check("rst_err",   32'(err[d]), 32'd0);
        check("rst_data",  dout[d], 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal;
    end

    initial begin
        int last_acc;
        logic [31:0] a, dat;
        logic w;
        int t;

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req[d] = 1'b0; addr[d] = '0; we[d] = 1'b0; din[d] = '0;
            last_rd[d] = '0; last_k[d] = 1'b1;
        end
        repeat (2) @(negedge clk);
        check_reset_outputs(0);
        check_reset_outputs(1);
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk);

        // Basic write then read of the same word via an unaligned address.
        op(0, 1'b1, 32'h0000_0010, 32'h4433_2211);
        op(0, 1'b0, 32'h0000_0013, 32'h0);

        // Out-of-range write must not alias onto address 0.
        op(0, 1'b1, 32'h0000_0000, 32'h0BAD_F00D);
        op(0, 1'b1, 32'h0001_0000, 32'hDEAD_BEEF);
        op(0, 1'b0, 32'h0000_0000, 32'h0);
        op(0, 1'b0, 32'h0001_0000, 32'h0);

        // Reset two edges into a write aborts it cleanly.
        op(0, 1'b1, 32'h0000_0020, 32'h0102_0304);
        op(0, 1'b0, 32'h0000_0020, 32'h0);
        t = 0;
        while (busy[0] !== 1'b0 && t < 50) begin @(negedge clk); t++; end
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; din[0] = 32'hAAAA_AAAA;
        @(posedge clk);
        #1 req[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst[0] = 1'b1;
        @(negedge clk);
        check_reset_outputs(0);
        @(posedge clk);
        #1 rst[0] = 1'b0;
        last_rd[0] = '0; last_k[0] = 1'b1;
        repeat (8) @(negedge clk);
        check("post_reset_data", dout[0], 32'd0);
        op(0, 1'b0, 32'h0000_0020, 32'h0);

        // Request held high: acceptances every LATENCY+2 edges, inputs churning each cycle.
        @(negedge clk);
        last_acc = -1;
        for (int k = 0; k < 40; k++) begin
            a = raddr(); dat = $urandom; w = 1'($urandom);
            req[0] = 1'b1; we[0] = w; addr[0] = a; din[0] = dat;
            if (busy[0] === 1'b0) begin
                accept(0, w, a, dat);
                if (last_acc >= 0) check("accept_spacing", cyc + 1 - last_acc, 32'd6);
                last_acc = cyc + 1;
            end
            @(negedge clk);
        end
        req[0] = 1'b0;
        t = 0;
        while (expq[0].size() != 0 && t < 50) begin @(negedge clk); t++; end
        if (expq[0].size() != 0) fail("hold_drain_timeout");

        // LATENCY=1: read then write back-to-back; write must not disturb read lanes.
        op(1, 1'b1, 32'h0000_0008, 32'hCAFE_0001);
        op(1, 1'b0, 32'h0000_0008, 32'h0);
        op(1, 1'b1, 32'h0000_0008, 32'h1234_5678);
        op(1, 1'b0, 32'h0000_0008, 32'h0);

        // Randomised traffic on both instances.
        for (int d = 0; d < 2; d++) begin
            repeat (25) op(d, 1'($urandom_range(0, 1)), raddr(), $urandom);
        end

        repeat (5) @(negedge clk);
        check("queue_empty_lat4", expq[0].size(), 32'd0);
        check("queue_empty_lat1", expq[1].size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
